// File: rtl/digit_serial_addsub15.sv
// 15-bit adder/subtractor evaluated digit-serially: five 3-bit carry-lookahead
// slices, one per clock, least significant slice first.
//
// state  | meaning
// IDLE   | waiting for start; operands and result registers hold
// RUN    | processing slice cnt (0..4), one slice per cycle
// DONE   | one-cycle done pulse; sum/cout/ovf final
module digit_serial_addsub15 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic        busy,
  output logic        done,
  output logic [14:0] sum,
  output logic        cout,
  output logic        ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        carry_reg;
  logic        c2_last;
  logic [14:0] a_reg;
  logic [14:0] b_reg;
  logic        sub_reg;

  logic [2:0]  a_sl;
  logic [2:0]  b_sl;
  logic [2:0]  g;
  logic [2:0]  p;
  logic [2:0]  s;
  logic        c0;
  logic        c1;
  logic        c2;
  logic        c3;

  always_comb begin
    a_sl = a_reg[2:0];
    b_sl = b_reg[2:0];
    case (cnt)
      3'd1: begin a_sl = a_reg[5:3];   b_sl = b_reg[5:3];   end
      3'd2: begin a_sl = a_reg[8:6];   b_sl = b_reg[8:6];   end
      3'd3: begin a_sl = a_reg[11:9];  b_sl = b_reg[11:9];  end
      3'd4: begin a_sl = a_reg[14:12]; b_sl = b_reg[14:12]; end
      default: begin a_sl = a_reg[2:0]; b_sl = b_reg[2:0]; end
    endcase
  end

  // The first slice takes its carry-in straight from the latched mode bit;
  // later slices chain through carry_reg.
  assign c0 = (cnt == 3'd0) ? sub_reg : carry_reg;

  assign g  = a_sl & b_sl;
  assign p  = a_sl ^ b_sl;
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign s  = p ^ {c2, c1, c0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      carry_reg <= 1'b0;
      c2_last   <= 1'b0;
      a_reg     <= 15'd0;
      b_reg     <= 15'd0;
      sub_reg   <= 1'b0;
      sum       <= 15'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b ^ {15{sub}};
            sub_reg   <= sub;
            carry_reg <= sub;
            cnt       <= 3'd0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          case (cnt)
            3'd0:    sum[2:0]   <= s;
            3'd1:    sum[5:3]   <= s;
            3'd2:    sum[8:6]   <= s;
            3'd3:    sum[11:9]  <= s;
            default: sum[14:12] <= s;
          endcase
          carry_reg <= c3;
          cnt       <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            c2_last <= c2;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Flags come from the held carries, so they stay put after done until the
  // next accepted start reloads carry_reg.
  assign cout = carry_reg;
  assign ovf  = c2_last ^ carry_reg;
  assign done = (state == S_DONE);
  assign busy = (state == S_RUN) || (state == S_DONE);

endmodule

// File: doc/digit_serial_addsub15.md
DIGIT_SERIAL_ADDSUB15 -- requirements
Module: digit_serial_addsub15

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. All state SHALL update on the rising edge of clk.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: sub  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port: a  input  15  operand A; sampled with start.
REQ-007 Port: b  input  15  operand B; sampled with start.
REQ-008 Port: busy  output  1  high while the state is RUN or DONE.
REQ-009 Port: done  output  1  one-cycle pulse; sum, cout and ovf are valid and final.
REQ-010 Port: sum  output  15  result, two's-complement modulo 2^15.
REQ-011 Port: cout  output  1  carry out of bit 14; for subtraction, 1 = no borrow (a >= b unsigned).
REQ-012 Port: ovf  output  1  signed overflow: carry into bit 14 XOR carry out of bit 14.

Function
REQ-013 The block SHALL compute the 15-bit result digit-serially as five 3-bit carry-lookahead slices, one slice per clock, least significant slice first.
REQ-014 Each slice SHALL use g_i = a_i & b'_i, p_i = a_i ^ b'_i, c1 = g0|p0c0, c2 = g1|p1g0|p1p0c0, c3 = g2|p2g1|p2p1g0|p2p1p0c0, and s_i = p_i ^ c_i, where b' = b ^ {15{sub}}.
REQ-015 The FSM states SHALL be IDLE, RUN and DONE, and the reset state SHALL be IDLE.
REQ-016 IDLE with start=1 SHALL latch a, b' and sub into operand registers, set carry_reg=sub and slice counter cnt=0, and go to RUN. IDLE with start=0 SHALL stay in IDLE.
REQ-017 Each RUN cycle SHALL process slice cnt (bits 3cnt+2..3cnt), write those three bits of the sum register, set carry_reg=c3, and increment cnt.
REQ-018 On the RUN cycle with cnt=4, the block SHALL also capture the carry into bit 14 (slice c2) for ovf, then go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, drive cout=carry_reg and ovf=c2_last^carry_reg, then go to IDLE.
REQ-020 Latency: if start is sampled at edge E0, the RUN edges SHALL be E1..E5, done SHALL be high between E5 and E6, and busy SHALL be low again after E6.
REQ-021 Start asserted in RUN or DONE SHALL be ignored; a new operation SHALL be accepted no earlier than the first IDLE cycle after done.
REQ-022 Start held high continuously SHALL produce back-to-back operations at a period of 7 cycles.
REQ-023 Changes on a, b or sub after start has been sampled SHALL NOT affect the operation in progress.
REQ-024 sum, cout and ovf SHALL hold their final values after done until the next accepted start. While RUN is in progress they MAY show partial values and are valid only when done=1 or after it.
REQ-025 Slices not yet processed SHALL keep the sum register's previous contents until they are overwritten.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set state=IDLE, cnt=0, carry_reg=0, operand registers=0, sum=0, cout=0, ovf=0, done=0 and busy=0, regardless of state.
REQ-027 Reset SHALL take priority over start at the same edge. An operation in progress when reset is applied SHALL be abandoned, and done SHALL NOT be produced for it.
REQ-028 The first start after reset is released SHALL be accepted at the first edge where rst=0 and start=1.

Verification
REQ-029 Add: a=100, b=200, sub=0 -> done exactly 6 edges after the start edge; sum=300, cout=0, ovf=0; busy high for 6 cycles.
REQ-030 Signed overflow: a=0x3FFF, b=0x0001, sub=0 -> sum=0x4000, cout=0, ovf=1. Unsigned wrap: a=0x7FFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
REQ-031 Subtract with borrow: a=5, b=7, sub=1 -> sum=0x7FFE, cout=0, ovf=0. Subtract with overflow: a=0x4000, b=0x0001, sub=1 -> sum=0x3FFF, cout=1, ovf=1.
REQ-032 Start during busy: start pulsed again in the 3rd RUN cycle with different operands -> ignored; the first result is unchanged, and exactly one done pulse occurs.
REQ-033 Reset mid-operation: rst=1 for one cycle during RUN with cnt=2 -> next cycle busy=0, sum=0, no done pulse; a following start with a=1, b=1 yields sum=2 on schedule.
REQ-034 Random regression: at least 1000 random (a, b, sub) with start held high, compared against a 16-bit reference model for sum, cout and ovf, with a 7-cycle period checked.
